// File: rtl/hs_bridge_pkg.sv
// Shared types for the 4-phase event bridge: channel phase encoding and
// the error-source codes reported on err_src.
package hs_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    RTZ  = 2'd3
  } phase_t;

  typedef logic [1:0] err_src_t;

  localparam err_src_t ERR_NONE  = 2'd0;
  localparam err_src_t ERR_IN    = 2'd1;
  localparam err_src_t ERR_OUT   = 2'd2;
  localparam err_src_t ERR_CLASH = 2'd3;

  // ao is high from the accepted Ao_PLUS until the accepted Ao_MINUS
  function automatic logic ao_level(input phase_t s);
    return (s == ACK) || (s == RTZ);
  endfunction

  // ro is high from the accepted Ro_PLUS until the accepted Ro_MINUS
  function automatic logic ro_level(input phase_t s);
    return (s == REQ) || (s == ACK);
  endfunction

endpackage

// File: rtl/hs_event_bridge_if.sv
// Handshake levels, MSFSM event pulses and error status of hs_event_bridge.
// slave = bridge side, master = environment/controller side.
interface hs_event_bridge_if;
  logic       ri;
  logic       ao;
  logic       ro;
  logic       ai;
  logic       Ri_PLUS;
  logic       Ri_MINUS;
  logic       Ai_PLUS;
  logic       Ai_MINUS;
  logic       Ro_PLUS;
  logic       Ro_MINUS;
  logic       Ao_PLUS;
  logic       Ao_MINUS;
  logic       err;
  logic [1:0] err_src;

  modport slave (
    input  ri, ai, Ro_PLUS, Ro_MINUS, Ao_PLUS, Ao_MINUS,
    output ao, ro, Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_MINUS, err, err_src
  );

  modport master (
    output ri, ai, Ro_PLUS, Ro_MINUS, Ao_PLUS, Ao_MINUS,
    input  ao, ro, Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_MINUS, err, err_src
  );
endinterface

// File: rtl/hs_edge_det.sv
// Level edge detector with registered rise/fall pulses. With HS_BRIDGE_SYNC_EN
// defined the level first passes a 2-flop synchronizer.
module hs_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise_det,
  output logic fall_det,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic level_s;
  logic hist;

`ifdef HS_BRIDGE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], level};
  end

  assign level_s = sync_q[1];
`else
  assign level_s = level;
`endif

  // detection feeds the phase FSM on the same edge the pulse is registered
  assign rise_det = level_s & ~hist;
  assign fall_det = ~level_s & hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      hist       <= level_s;
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
    end
  end

endmodule

// File: rtl/hs_event_bridge.sv
// Bridges 4-phase ri/ao and ro/ai handshakes to MSFSM event pulses and
// flags protocol violations. HS_BRIDGE_SYNC_EN adds input synchronizers.
module hs_event_bridge
  import hs_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  hs_event_bridge_if.slave bus
);

  logic     ri_rise, ri_fall, ai_rise, ai_fall;
  logic     ri_plus_q, ri_minus_q, ai_plus_q, ai_minus_q;
  phase_t   in_state, in_next, out_state, out_next;
  logic     ao_q, ro_q, ao_next, ro_next;
  logic     in_viol, out_viol;
  logic     ao_clash, ro_clash;
  logic     ao_plus, ao_minus, ro_plus, ro_minus;
  logic     err_q;
  err_src_t err_src_q, viol_code;

  hs_edge_det u_ri_det (
    .clk        (clk),
    .reset      (reset),
    .level      (bus.ri),
    .rise_det   (ri_rise),
    .fall_det   (ri_fall),
    .rise_pulse (ri_plus_q),
    .fall_pulse (ri_minus_q)
  );

  hs_edge_det u_ai_det (
    .clk        (clk),
    .reset      (reset),
    .level      (bus.ai),
    .rise_det   (ai_rise),
    .fall_det   (ai_fall),
    .rise_pulse (ai_plus_q),
    .fall_pulse (ai_minus_q)
  );

  // opposing controller events in one cycle cancel each other
  assign ao_clash = bus.Ao_PLUS & bus.Ao_MINUS;
  assign ro_clash = bus.Ro_PLUS & bus.Ro_MINUS;
  assign ao_plus  = bus.Ao_PLUS  & ~ao_clash;
  assign ao_minus = bus.Ao_MINUS & ~ao_clash;
  assign ro_plus  = bus.Ro_PLUS  & ~ro_clash;
  assign ro_minus = bus.Ro_MINUS & ~ro_clash;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state  <= IDLE;
      out_state <= IDLE;
      ao_q      <= 1'b0;
      ro_q      <= 1'b0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      ao_q      <= ao_next;
      ro_q      <= ro_next;
    end
  end

  // each phase has exactly one legal event; anything else is a violation
  always_comb begin
    in_next = in_state;
    in_viol = 1'b0;
    case (in_state)
      IDLE: begin
        if (ri_rise) in_next = REQ;
        in_viol = ri_fall | ao_plus | ao_minus;
      end
      REQ: begin
        if (ao_plus) in_next = ACK;
        in_viol = ri_rise | ri_fall | ao_minus;
      end
      ACK: begin
        if (ri_fall) in_next = RTZ;
        in_viol = ri_rise | ao_plus | ao_minus;
      end
      RTZ: begin
        if (ao_minus) in_next = IDLE;
        in_viol = ri_rise | ri_fall | ao_plus;
      end
      default: in_next = IDLE;
    endcase
  end

  always_comb begin
    out_next = out_state;
    out_viol = 1'b0;
    case (out_state)
      IDLE: begin
        if (ro_plus) out_next = REQ;
        out_viol = ai_rise | ai_fall | ro_minus;
      end
      REQ: begin
        if (ai_rise) out_next = ACK;
        out_viol = ai_fall | ro_plus | ro_minus;
      end
      ACK: begin
        if (ro_minus) out_next = RTZ;
        out_viol = ai_rise | ai_fall | ro_plus;
      end
      RTZ: begin
        if (ai_fall) out_next = IDLE;
        out_viol = ai_rise | ro_plus | ro_minus;
      end
      default: out_next = IDLE;
    endcase
  end

  always_comb begin
    ao_next   = ao_level(in_next);
    ro_next   = ro_level(out_next);
    viol_code = ERR_NONE;
    if (in_viol)                    viol_code = ERR_IN;
    else if (out_viol)              viol_code = ERR_OUT;
    else if (ao_clash || ro_clash)  viol_code = ERR_CLASH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      err_src_q <= ERR_NONE;
    end else if (!err_q && (viol_code != ERR_NONE)) begin
      err_q     <= 1'b1;
      err_src_q <= viol_code;
    end
  end

  assign bus.ao       = ao_q;
  assign bus.ro       = ro_q;
  assign bus.Ri_PLUS  = ri_plus_q;
  assign bus.Ri_MINUS = ri_minus_q;
  assign bus.Ai_PLUS  = ai_plus_q;
  assign bus.Ai_MINUS = ai_minus_q;
  assign bus.err      = err_q;
  assign bus.err_src  = err_src_q;

endmodule

// File: tb/tb_hs_event_bridge.sv
// Self-checking bench for hs_event_bridge: expected event pulses are queued
// with their due cycle when the input level is driven, and matched on arrival.
module tb_hs_event_bridge;

`ifdef HS_BRIDGE_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  localparam int unsigned K_RI_P = 0;
  localparam int unsigned K_RI_M = 1;
  localparam int unsigned K_AI_P = 2;
  localparam int unsigned K_AI_M = 3;

  localparam int unsigned C_AO_P = 0;
  localparam int unsigned C_AO_M = 1;
  localparam int unsigned C_RO_P = 2;
  localparam int unsigned C_RO_M = 3;

  typedef struct {
    int unsigned kind;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [3:0]  mon_p;

  hs_event_bridge_if bus ();

  hs_event_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int unsigned kind, input int unsigned delay);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + delay;
    sb_q.push_back(e);
  endtask

  task automatic ctl_pulse(input int unsigned which);
    case (which)
      C_AO_P:  bus.Ao_PLUS  = 1'b1;
      C_AO_M:  bus.Ao_MINUS = 1'b1;
      C_RO_P:  bus.Ro_PLUS  = 1'b1;
      default: bus.Ro_MINUS = 1'b1;
    endcase
    step(1);
    bus.Ao_PLUS  = 1'b0;
    bus.Ao_MINUS = 1'b0;
    bus.Ro_PLUS  = 1'b0;
    bus.Ro_MINUS = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.ri       = 1'b0;
    bus.ai       = 1'b0;
    bus.Ao_PLUS  = 1'b0;
    bus.Ao_MINUS = 1'b0;
    bus.Ro_PLUS  = 1'b0;
    bus.Ro_MINUS = 1'b0;
    step(2);
    check("rst_ao", bus.ao, 0);
    check("rst_ro", bus.ro, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_src", bus.err_src, 0);
    check("rst_pulses", {bus.Ai_MINUS, bus.Ai_PLUS, bus.Ri_MINUS, bus.Ri_PLUS}, 0);
    reset = 1'b0;
    step(1);
  endtask

  // every pulse seen must be the next queued expectation, on its due cycle
  always @(negedge clk) begin
    mon_p = {bus.Ai_MINUS, bus.Ai_PLUS, bus.Ri_MINUS, bus.Ri_PLUS};
    for (int k = 0; k < 4; k++) begin
      if (mon_p[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", k, 99);
        end else begin
          mon_e = sb_q.pop_front();
          check("pulse_kind", k, mon_e.kind);
          check("pulse_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    do_reset();

    // full input-channel handshakes, twice to prove return to IDLE
    for (int i = 0; i < 2; i++) begin
      bus.ri = 1'b1;
      expect_pulse(K_RI_P, LAT);
      step(LAT);
      ctl_pulse(C_AO_P);
      check("in_ao_set", bus.ao, 1);
      bus.ri = 1'b0;
      expect_pulse(K_RI_M, LAT);
      step(LAT);
      ctl_pulse(C_AO_M);
      check("in_ao_clr", bus.ao, 0);
      check("in_err", bus.err, 0);
    end

    // full output-channel handshakes, twice
    for (int i = 0; i < 2; i++) begin
      ctl_pulse(C_RO_P);
      check("out_ro_set", bus.ro, 1);
      bus.ai = 1'b1;
      expect_pulse(K_AI_P, LAT);
      step(LAT);
      ctl_pulse(C_RO_M);
      check("out_ro_clr", bus.ro, 0);
      bus.ai = 1'b0;
      expect_pulse(K_AI_M, LAT);
      step(LAT);
      check("out_err", bus.err, 0);
    end

    // both channels active in the same cycles
    bus.ri = 1'b1;
    expect_pulse(K_RI_P, LAT);
    bus.Ro_PLUS = 1'b1;
    step(1);
    bus.Ro_PLUS = 1'b0;
    check("cc_ro_set", bus.ro, 1);
    step(LAT - 1);
    bus.ai = 1'b1;
    expect_pulse(K_AI_P, LAT);
    bus.Ao_PLUS = 1'b1;
    step(1);
    bus.Ao_PLUS = 1'b0;
    check("cc_ao_set", bus.ao, 1);
    step(LAT - 1);
    bus.ri = 1'b0;
    expect_pulse(K_RI_M, LAT);
    bus.Ro_MINUS = 1'b1;
    step(1);
    bus.Ro_MINUS = 1'b0;
    check("cc_ro_clr", bus.ro, 0);
    step(LAT - 1);
    bus.ai = 1'b0;
    expect_pulse(K_AI_M, LAT);
    bus.Ao_MINUS = 1'b1;
    step(1);
    bus.Ao_MINUS = 1'b0;
    check("cc_ao_clr", bus.ao, 0);
    step(LAT - 1);
    check("cc_err", bus.err, 0);

    // Ao_PLUS with input channel idle
    ctl_pulse(C_AO_P);
    check("ill_ao", bus.ao, 0);
    check("ill_err", bus.err, 1);
    check("ill_err_src", bus.err_src, 1);

    // Ro_PLUS/Ro_MINUS together while ro high; later violation must not overwrite source
    do_reset();
    ctl_pulse(C_RO_P);
    check("clash_pre_ro", bus.ro, 1);
    check("clash_pre_err", bus.err, 0);
    bus.Ro_PLUS  = 1'b1;
    bus.Ro_MINUS = 1'b1;
    step(1);
    bus.Ro_PLUS  = 1'b0;
    bus.Ro_MINUS = 1'b0;
    check("clash_ro", bus.ro, 1);
    check("clash_err", bus.err, 1);
    check("clash_err_src", bus.err_src, 3);
    ctl_pulse(C_AO_P);
    check("sticky_err", bus.err, 1);
    check("sticky_err_src", bus.err_src, 3);

    // same-cycle input and output violations: lower code recorded
    do_reset();
    bus.Ao_PLUS  = 1'b1;
    bus.Ro_MINUS = 1'b1;
    step(1);
    bus.Ao_PLUS  = 1'b0;
    bus.Ro_MINUS = 1'b0;
    check("tie_err", bus.err, 1);
    check("tie_err_src", bus.err_src, 1);

    // ri fall while in REQ: pulse still issued, FSM stays in REQ
    do_reset();
    bus.ri = 1'b1;
    expect_pulse(K_RI_P, LAT);
    step(LAT);
    bus.ri = 1'b0;
    expect_pulse(K_RI_M, LAT);
    step(LAT);
    check("edge_ill_err", bus.err, 1);
    check("edge_ill_err_src", bus.err_src, 1);
    ctl_pulse(C_AO_P);
    check("edge_ill_ao", bus.ao, 1);

    // ai rise with output channel idle
    do_reset();
    bus.ai = 1'b1;
    expect_pulse(K_AI_P, LAT);
    step(LAT);
    check("ai_ill_err", bus.err, 1);
    check("ai_ill_err_src", bus.err_src, 2);
    check("ai_ill_ro", bus.ro, 0);
    bus.ai = 1'b0;
    expect_pulse(K_AI_M, LAT);
    step(LAT);

    // reset in ACK with ri held high: handshake abandoned, rise seen again
    do_reset();
    bus.ri = 1'b1;
    expect_pulse(K_RI_P, LAT);
    step(LAT);
    ctl_pulse(C_AO_P);
    check("mid_ao_pre", bus.ao, 1);
    reset = 1'b1;
    step(2);
    check("mid_ao_rst", bus.ao, 0);
    check("mid_err_rst", bus.err, 0);
    reset = 1'b0;
    expect_pulse(K_RI_P, LAT);
    step(LAT);
    ctl_pulse(C_AO_P);
    check("mid_ao_post", bus.ao, 1);
    check("mid_err_post", bus.err, 0);
    bus.ri = 1'b0;
    expect_pulse(K_RI_M, LAT);
    step(LAT);
    ctl_pulse(C_AO_M);
    check("mid_ao_clr", bus.ao, 0);

    step(LAT + 4);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
